// File: rtl/ps2_kbd_ascii_if.sv
// Keyboard-side and video-memory-side signals of the PS/2 ASCII front end.
// master is the front end itself; slave is the keyboard line driver plus key consumer.
interface ps2_kbd_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_in;
  logic       p_valid;
  logic       frame_err;
  logic       shift_o;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_in,
    output p_valid,
    output frame_err,
    output shift_o
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_in,
    input  p_valid,
    input  frame_err,
    input  shift_o
  );
endinterface

// File: rtl/ps2_kbd_ascii.sv
// PS/2 set-2 keyboard receiver: frames bits, checks parity, tracks make/break/extended/shift
// and emits one ASCII write pulse per printable or control key press.
module ps2_kbd_ascii #(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  ps2_kbd_ascii_if.master   bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  // Each stage holds {ps2_clk, ps2_data}; idle lines are high.
  logic [SYNC_STAGES-1:0][1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_reg[gi] <= 2'b11;
          else        sync_reg[gi] <= {bus.ps2_clk, bus.ps2_data};
        end
      end else begin : g_chain
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_reg[gi] <= 2'b11;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic ps2_clk_s;
  logic ps2_data_s;
  logic clk_prev_reg;
  logic fall;

  assign ps2_clk_s  = sync_reg[SYNC_STAGES-1][1];
  assign ps2_data_s = sync_reg[SYNC_STAGES-1][0];
  assign fall       = clk_prev_reg & ~ps2_clk_s;

  // Bit-level receiver
  logic [3:0]    bit_cnt_reg;
  logic [9:0]    frame_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    code_reg;
  logic          code_valid_reg;
  logic          frame_err_reg;
  logic          accept;

  // After ten shifts: bit0 = start, bits 8:1 = data LSB first, bit9 = parity; stop is live.
  assign accept = ~frame_reg[0] & ps2_data_s & (^frame_reg[9:1]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_prev_reg   <= 1'b1;
      bit_cnt_reg    <= 4'd0;
      frame_reg      <= 10'd0;
      timer_reg      <= '0;
      code_reg       <= 8'd0;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      clk_prev_reg   <= ps2_clk_s;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (fall) begin
        timer_reg <= '0;
        if (bit_cnt_reg == 4'd10) begin
          bit_cnt_reg <= 4'd0;
          if (accept) begin
            code_reg       <= frame_reg[8:1];
            code_valid_reg <= 1'b1;
          end else begin
            frame_err_reg  <= 1'b1;
          end
        end else begin
          frame_reg   <= {ps2_data_s, frame_reg[9:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else if (bit_cnt_reg != 4'd0) begin
        // A stalled partial frame is silently abandoned.
        if (timer_reg == TIMER_LAST) begin
          bit_cnt_reg <= 4'd0;
          timer_reg   <= '0;
        end else begin
          timer_reg   <= timer_reg + 1'b1;
        end
      end
    end
  end

  // Returns {mapped, ascii} for a make code given the current shift state.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic sh);
    logic [4:0] letter;
    logic       is_letter;
    logic [8:0] result;
    letter    = 5'd0;
    is_letter = 1'b1;
    result    = 9'd0;
    case (code)
      8'h1C: letter = 5'd0;
      8'h32: letter = 5'd1;
      8'h21: letter = 5'd2;
      8'h23: letter = 5'd3;
      8'h24: letter = 5'd4;
      8'h2B: letter = 5'd5;
      8'h34: letter = 5'd6;
      8'h33: letter = 5'd7;
      8'h43: letter = 5'd8;
      8'h3B: letter = 5'd9;
      8'h42: letter = 5'd10;
      8'h4B: letter = 5'd11;
      8'h3A: letter = 5'd12;
      8'h31: letter = 5'd13;
      8'h44: letter = 5'd14;
      8'h4D: letter = 5'd15;
      8'h15: letter = 5'd16;
      8'h2D: letter = 5'd17;
      8'h1B: letter = 5'd18;
      8'h2C: letter = 5'd19;
      8'h3C: letter = 5'd20;
      8'h2A: letter = 5'd21;
      8'h1D: letter = 5'd22;
      8'h22: letter = 5'd23;
      8'h35: letter = 5'd24;
      8'h1A: letter = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      result = {1'b1, (sh ? 8'h41 : 8'h61) + {3'b000, letter}};
    end else begin
      case (code)
        8'h45: result = {1'b1, 8'h30};
        8'h16: result = {1'b1, 8'h31};
        8'h1E: result = {1'b1, 8'h32};
        8'h26: result = {1'b1, 8'h33};
        8'h25: result = {1'b1, 8'h34};
        8'h2E: result = {1'b1, 8'h35};
        8'h36: result = {1'b1, 8'h36};
        8'h3D: result = {1'b1, 8'h37};
        8'h3E: result = {1'b1, 8'h38};
        8'h46: result = {1'b1, 8'h39};
        8'h29: result = {1'b1, 8'h20};
        8'h66: result = {1'b1, 8'h08};
        8'h5A: result = {1'b1, 8'h0A};
        default: result = 9'd0;
      endcase
    end
    return result;
  endfunction

  // Scancode decoder
  state_t     state_reg, state_next;
  logic       shift_held_reg, shift_next;
  logic       emit;
  logic [8:0] mapped;
  logic       is_shift_code;
  logic [7:0] key_in_reg;
  logic       p_valid_reg;

  assign is_shift_code = (code_reg == 8'h12) || (code_reg == 8'h59);

  always_comb begin
    state_next = state_reg;
    shift_next = shift_held_reg;
    emit       = 1'b0;
    mapped     = map_code(code_reg, shift_held_reg);
    if (code_valid_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (code_reg == 8'hF0)      state_next = ST_BREAK;
          else if (code_reg == 8'hE0) state_next = ST_EXT;
          else if (is_shift_code)     shift_next = 1'b1;
          else if (mapped[8])         emit       = 1'b1;
        end
        ST_BREAK: begin
          if (is_shift_code) shift_next = 1'b0;
          state_next = ST_IDLE;
        end
        ST_EXT: begin
          state_next = (code_reg == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
        end
        ST_EXT_BREAK: state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      shift_held_reg <= 1'b0;
      key_in_reg     <= 8'd0;
      p_valid_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_held_reg <= shift_next;
      p_valid_reg    <= emit;
      if (emit) key_in_reg <= mapped[7:0];
    end
  end

  assign bus.key_in    = key_in_reg;
  assign bus.p_valid   = p_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.shift_o   = shift_held_reg;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed bench for ps2_kbd_ascii: drives PS/2 frames and checks emissions against a
// table-driven keyboard model plus hand-computed literals.
module tb_ps2_kbd_ascii;
  localparam int SYNC = 3;
  localparam int TMO  = 2000;
  localparam int H    = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ps2_kbd_ascii_if bus();

  ps2_kbd_ascii #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Keyboard model: pending prefix bytes and the single shift flag.
  bit         m_break = 1'b0;
  bit         m_ext = 1'b0;
  bit         m_shift = 1'b0;
  logic [7:0] exp_key_q [$];
  bit         exp_sh_q [$];
  int         ferr_pending = 0;
  int         ferr_seen = 0;
  logic [7:0] seen_q [$];
  int         last_pv_cyc = 0;
  int         stop_cyc = 0;
  bit         pv_prev = 1'b0;

  function automatic int lookup(input logic [7:0] code, input bit sh);
    for (int i = 0; i < 26; i++)
      if (letters[i] == code) return (sh ? 32'h41 : 32'h61) + i;
    for (int i = 0; i < 10; i++)
      if (digits[i] == code) return 32'h30 + i;
    if (code == 8'h29) return 32'h20;
    if (code == 8'h66) return 32'h08;
    if (code == 8'h5A) return 32'h0A;
    return -1;
  endfunction

  task automatic model_feed(input logic [7:0] code);
    int a;
    if (m_ext) begin
      // Extended keys: swallow the key and its break entirely.
      if (code == 8'hF0 && !m_break) m_break = 1'b1;
      else begin m_ext = 1'b0; m_break = 1'b0; end
    end else if (m_break) begin
      if (code == 8'h12 || code == 8'h59) m_shift = 1'b0;
      m_break = 1'b0;
    end else if (code == 8'hF0) m_break = 1'b1;
    else if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'h12 || code == 8'h59) m_shift = 1'b1;
    else begin
      a = lookup(code, m_shift);
      if (a >= 0) begin
        exp_key_q.push_back(a[7:0]);
        exp_sh_q.push_back(m_shift);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every emission and error pulse is matched against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.p_valid) begin
        checks++;
        if (pv_prev) begin
          errors++;
          $display("FAIL pvalid_spacing got consecutive pulses required isolated pulse");
        end
        checks++;
        if (exp_key_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pvalid got key 0x%02h required no pulse", bus.key_in);
        end else begin
          logic [7:0] ek;
          bit es;
          ek = exp_key_q.pop_front();
          es = exp_sh_q.pop_front();
          if (bus.key_in !== ek || bus.shift_o !== es) begin
            errors++;
            $display("FAIL emission got key 0x%02h shift %0b required key 0x%02h shift %0b",
                     bus.key_in, bus.shift_o, ek, es);
          end
        end
        seen_q.push_back(bus.key_in);
        last_pv_cyc = cyc;
        $display("emit key_in=0x%02h shift_o=%0b cycle=%0d", bus.key_in, bus.shift_o, cyc);
      end
      if (bus.frame_err) begin
        checks++;
        ferr_seen++;
        if (ferr_pending == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err got pulse required none");
        end else ferr_pending--;
      end
    end
    pv_prev = bus.p_valid;
  end

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = bits[i];
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    if (bad_par) ferr_pending++;
    else model_feed(code);
    $display("frame code=0x%02h bad_parity=%0b", code, bad_par);
    send_bits(bits, 11);
    repeat (30) @(negedge clk);
  endtask

  task automatic drain();
    repeat (40) @(negedge clk);
    chk("pending_keys", exp_key_q.size(), 0);
    chk("pending_frame_err", ferr_pending, 0);
  endtask

  initial begin
    logic [7:0] seq2 [7];
    logic [7:0] seq5 [6];
    int f0;
    seq2 = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    seq5 = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h45};
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_key_in", bus.key_in, 0);
    chk("reset_p_valid", bus.p_valid, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_shift_o", bus.shift_o, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single 'a' and its latency from stop-bit fall
    seen_q.delete();
    send_frame(8'h1C, 1'b0);
    drain();
    chk("t1_count", seen_q.size(), 1);
    chk("t1_key", bus.key_in, 8'h61);
    chk("t1_latency", last_pv_cyc - stop_cyc, SYNC + 2);

    // 2: shift make/break
    seen_q.delete();
    for (int i = 0; i < 7; i++) begin
      send_frame(seq2[i], 1'b0);
      if (i == 0) chk("t2_shift_held", bus.shift_o, 1);
    end
    drain();
    chk("t2_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("t2_first", seen_q[0], 8'h41);
      chk("t2_second", seen_q[1], 8'h61);
    end
    chk("t2_shift_released", bus.shift_o, 0);

    // 3: parity error then a good space
    seen_q.delete();
    f0 = ferr_seen;
    send_frame(8'h1C, 1'b1);
    drain();
    chk("t3_err_pulses", ferr_seen - f0, 1);
    chk("t3_no_emit", seen_q.size(), 0);
    send_frame(8'h29, 1'b0);
    drain();
    chk("t3_space", bus.key_in, 8'h20);

    // 4: abandoned partial frame then enter
    seen_q.delete();
    send_bits(11'h7FE, 5);
    repeat (TMO + 1) @(negedge clk);
    send_frame(8'h5A, 1'b0);
    drain();
    chk("t4_count", seen_q.size(), 1);
    chk("t4_enter", bus.key_in, 8'h0A);

    // 5: extended keys are ignored
    seen_q.delete();
    for (int i = 0; i < 6; i++) send_frame(seq5[i], 1'b0);
    drain();
    chk("t5_count", seen_q.size(), 1);
    chk("t5_zero", bus.key_in, 8'h30);

    // 6: reset mid-frame with shift held
    seen_q.delete();
    send_frame(8'h12, 1'b0);
    chk("t6_shift_before", bus.shift_o, 1);
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 7);
    reset = 1'b0;
    m_break = 1'b0; m_ext = 1'b0; m_shift = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_reset_key_in", bus.key_in, 0);
    chk("t6_reset_shift", bus.shift_o, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h1B, 1'b0);
    drain();
    chk("t6_count", seen_q.size(), 1);
    chk("t6_key", bus.key_in, 8'h73);
    chk("t6_shift_after", bus.shift_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
